// File: rtl/led_pattern_sequencer.sv
// Running-light sequencer for a 4-LED bank: 1 kHz tick prescaler, step counter, pattern modes cycled by KEY.
// Define LED_SEQ_DEBOUNCE_EN to insert a DEBOUNCE_CYC stability filter on the synchronized KEY.
module led_pattern_sequencer #(
  parameter int TICK_DIV     = 50_000,
  parameter int STEP_TICKS   = 250,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       KEY,
  input  logic       PAUSE,
  output logic [3:0] LED,
  output logic [1:0] MODE,
  output logic       STEP
);

  typedef enum logic [1:0] {
    SHIFT_L  = 2'd0,
    SHIFT_R  = 2'd1,
    PINGPONG = 2'd2,
    BLINK    = 2'd3
  } mode_t;

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int STEP_W  = $clog2(STEP_TICKS);

  if (TICK_DIV < 2 || STEP_TICKS < 2 || DEBOUNCE_CYC < 1) begin : g_param_check
    $error("led_pattern_sequencer: TICK_DIV and STEP_TICKS must be >= 2, DEBOUNCE_CYC >= 1");
  end

  logic               key_sync_p0;
  logic               key_sync_p1;
  logic               key_cond;
  logic               key_prev_p2;
  logic               key_evt;
  logic [PRESC_W-1:0] presc;
  logic [STEP_W-1:0]  step_cnt;
  logic               tick;
  logic               step_fire;
  logic               dir_up;
  mode_t              mode_q;
  logic [4:0]         nxt;

  // Returns {direction, led} for the next step of the given pattern.
  function automatic logic [4:0] next_pattern(input mode_t md, input logic [3:0] led,
                                              input logic up);
    logic [3:0] nl;
    logic       nu;
    nl = led;
    nu = up;
    case (md)
      SHIFT_L: nl = {led[2:0], led[3]};
      SHIFT_R: nl = {led[0], led[3:1]};
      PINGPONG: begin
        if (up) begin
          if (led == 4'b1000) begin
            nl = 4'b0100;
            nu = 1'b0;
          end else begin
            nl = {led[2:0], 1'b0};
          end
        end else begin
          if (led == 4'b0001) begin
            nl = 4'b0010;
            nu = 1'b1;
          end else begin
            nl = {1'b0, led[3:1]};
          end
        end
      end
      BLINK:   nl = (led == 4'b1111) ? 4'b0000 : 4'b1111;
      default: nl = 4'b0001;
    endcase
    return {nu, nl};
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: edge-detect register on the conditioned level
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      key_sync_p0 <= 1'b0;
      key_sync_p1 <= 1'b0;
      key_prev_p2 <= 1'b0;
    end else begin
      key_sync_p0 <= KEY;
      key_sync_p1 <= key_sync_p0;
      key_prev_p2 <= key_cond;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

  logic [DB_W-1:0] db_cnt;
  logic            key_db;

  // The accepted level flips only after DEBOUNCE_CYC consecutive samples at the other value.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (key_sync_p1 == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
      db_cnt <= '0;
      key_db <= key_sync_p1;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign key_cond = key_db;
`else
  assign key_cond = key_sync_p1;
`endif

  assign key_evt   = key_cond & ~key_prev_p2;
  assign tick      = (presc == PRESC_W'(TICK_DIV - 1));
  assign step_fire = tick & ~PAUSE & (step_cnt == STEP_W'(STEP_TICKS - 1));
  assign nxt       = next_pattern(mode_q, LED, dir_up);

  // A KEY event restarts the timebase and takes priority over a coincident step.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      presc    <= '0;
      step_cnt <= '0;
      mode_q   <= SHIFT_L;
      dir_up   <= 1'b1;
      LED      <= 4'b0001;
      STEP     <= 1'b0;
    end else if (key_evt) begin
      presc    <= '0;
      step_cnt <= '0;
      mode_q   <= mode_t'(mode_q + 2'd1);
      dir_up   <= 1'b1;
      LED      <= 4'b0001;
      STEP     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      STEP  <= step_fire;
      if (tick && !PAUSE) begin
        step_cnt <= step_fire ? '0 : step_cnt + 1'b1;
      end
      if (step_fire) begin
        dir_up <= nxt[4];
        LED    <= nxt[3:0];
      end
    end
  end

  assign MODE = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random KEY/PAUSE/RESET traffic,
// checked every cycle against a count-based reference model.
module tb_led_pattern_sequencer;

  localparam int TICK_DIV     = 4;
  localparam int STEP_TICKS   = 3;
  localparam int DEBOUNCE_CYC = 5;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int LR  = DEBOUNCE_CYC;
  localparam int LAT = 2;
`else
  localparam int LR  = 1;
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       pause;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step;

  int checks   = 0;
  int failures = 0;

  bit keyh  [0:8191];
  bit condh [0:8191];
  int n        = 0;
  int last_rst = 0;
  int m_mode   = 0;
  int m_k      = 0;
  int m_c      = 0;
  int m_act    = 0;
  bit m_step   = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .STEP_TICKS  (STEP_TICKS),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .KEY  (key),
    .PAUSE(pause),
    .LED  (led),
    .MODE (mode),
    .STEP (step)
  );

  // Conditioned KEY level seen at edge e: value of the latest window of LR equal
  // raw samples ending no later than sample e-1-LAT, restricted to after the last reset.
  function automatic bit cond_at(int e);
    for (int j = e - 1 - LAT; j - LR + 1 > last_rst; j--) begin
      bit same;
      same = 1'b1;
      for (int i = j - LR + 1; i < j; i++) if (keyh[i] != keyh[j]) same = 1'b0;
      if (same) return keyh[j];
    end
    return 1'b0;
  endfunction

  // LED after k steps in mode md, starting from 0001.
  function automatic logic [3:0] pat(int md, int k);
    case (md)
      0: return 4'(1 << (k % 4));
      1: case (k % 4)
           0: return 4'b0001;
           1: return 4'b1000;
           2: return 4'b0100;
           default: return 4'b0010;
         endcase
      2: case (k % 6)
           0: return 4'b0001;
           1: return 4'b0010;
           2: return 4'b0100;
           3: return 4'b1000;
           4: return 4'b0100;
           default: return 4'b0010;
         endcase
      default: return (k == 0) ? 4'b0001 : ((k % 2 == 1) ? 4'b1111 : 4'b0000);
    endcase
  endfunction

  task automatic cycle();
    bit c_now;
    bit evt;
    bit tck;
    logic [3:0] e_led;
    @(posedge clk);
    n++;
    if (rst) begin
      keyh[n]  = 1'b0;
      condh[n] = 1'b0;
      last_rst = n;
      m_mode = 0; m_k = 0; m_c = 0; m_act = 0; m_step = 1'b0;
    end else begin
      keyh[n]  = key;
      c_now    = cond_at(n);
      condh[n] = c_now;
      evt      = c_now && !condh[n-1];
      if (evt) begin
        m_mode = (m_mode + 1) % 4;
        m_k = 0; m_c = 0; m_act = 0; m_step = 1'b0;
      end else begin
        tck    = (m_c % TICK_DIV) == TICK_DIV - 1;
        m_c++;
        m_step = 1'b0;
        if (tck && !pause) begin
          m_act++;
          if (m_act % STEP_TICKS == 0) begin
            m_k++;
            m_step = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    e_led = pat(m_mode, m_k);
    checks++;
    assert (led === e_led) else begin
      failures++;
      $error("FAIL led n=%0d got=%b exp=%b", n, led, e_led);
    end
    checks++;
    assert (mode === 2'(m_mode)) else begin
      failures++;
      $error("FAIL mode n=%0d got=%0d exp=%0d", n, mode, m_mode);
    end
    checks++;
    assert (step === m_step) else begin
      failures++;
      $error("FAIL step n=%0d got=%b exp=%b", n, step, m_step);
    end
  endtask

  task automatic run(int cnt);
    for (int i = 0; i < cnt; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; key = 1'b0; pause = 1'b0;
    run(3);
    checks++;
    assert (led === 4'b0001 && mode === 2'd0 && step === 1'b0) else begin
      failures++;
      $error("FAIL reset_state got led=%b mode=%0d step=%b exp led=0001 mode=0 step=0", led, mode, step);
    end
    rst = 1'b0;
    run(60);

    // Four presses: through PINGPONG and BLINK, then wrap to mode 0.
    for (int p = 0; p < 4; p++) begin
      key = 1'b1; run(15);
      key = 1'b0; run(100);
    end

    // Pause from cycle 5 for 30 cycles.
    rst = 1'b1; run(1); rst = 1'b0;
    run(4); pause = 1'b1; run(30); pause = 1'b0; run(60);

    // KEY event landing on the first step wrap.
    rst = 1'b1; run(1); rst = 1'b0;
    run(11 - LAT - LR); key = 1'b1; run(20); key = 1'b0; run(30);

    // Bouncing KEY then held high.
    for (int b = 0; b < 10; b++) begin
      key = ~key; run(2);
    end
    key = 1'b1; run(40); key = 1'b0; run(20);

    // Reset mid-step in PINGPONG with LED=0100.
    rst = 1'b1; run(1); rst = 1'b0; run(2);
    key = 1'b1; run(10); key = 1'b0; run(10);
    key = 1'b1; run(10); key = 1'b0;
    for (int i = 0; i < 100 && led !== 4'b0100; i++) cycle();
    checks++;
    assert (led === 4'b0100 && mode === 2'd2) else begin
      failures++;
      $error("FAIL reach_pingpong_0100 got led=%b mode=%0d exp led=0100 mode=2", led, mode);
    end
    run(5);
    rst = 1'b1; run(1);
    checks++;
    assert (led === 4'b0001 && mode === 2'd0 && step === 1'b0) else begin
      failures++;
      $error("FAIL mid_step_reset got led=%b mode=%0d step=%b exp led=0001 mode=0 step=0", led, mode, step);
    end
    rst = 1'b0;
    run(60);

    // Random KEY/PAUSE traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) key = ~key;
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0; pause = 1'b0; key = 1'b0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
